ping_pong_buffer: RTL

Parametrised double-bank (ping-pong) stream buffer with valid/ready handshakes on both sides. A producer fills one bank while a consumer drains the other. Banks swap automatically when a bank fills or when the producer closes a short frame with `last_input`. It sits between a bursty word producer and a consumer that needs whole, contiguous frames of up to `BANK_DEPTH` words, and sustains one word per cycle in steady state.

---
 rtl/ping_pong_buffer_if.sv | 25 ++
 rtl/ping_pong_buffer.sv | 91 +++++++++
 2 files changed

// File: rtl/ping_pong_buffer_if.sv
// Producer/consumer handshake bundle for ping_pong_buffer.
// The buffer itself connects through the slave modport.
interface ping_pong_buffer_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] data_input;
  logic                  valid;
  logic                  last_input;
  logic                  ready_input;
  logic [DATA_WIDTH-1:0] data_output;
  logic                  data_out_valid;
  logic                  data_out_last;
  logic                  data_out_ready;
  logic [1:0]            bank_full;

  modport slave (
    input  data_input, valid, last_input, data_out_ready,
    output ready_input, data_output, data_out_valid, data_out_last, bank_full
  );

  modport master (
    output data_input, valid, last_input, data_out_ready,
    input  ready_input, data_output, data_out_valid, data_out_last, bank_full
  );
endinterface

// File: rtl/ping_pong_buffer.sv
// Double-bank stream buffer: the producer fills one bank while the consumer
// drains the other. A bank swaps when it fills or the producer closes a frame.
module ping_pong_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BANK_DEPTH = 4
) (
  input logic               clock,
  input logic               reset,
  ping_pong_buffer_if.slave bus
);
  localparam int unsigned AW = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
  localparam int unsigned LW = $clog2(BANK_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [2][BANK_DEPTH];
  logic [1:0]            full_q, full_d;
  logic [LW-1:0]         len_q [2];
  logic [LW-1:0]         len_d [2];
  logic                  wr_sel_q, wr_sel_d;
  logic                  rd_sel_q, rd_sel_d;
  logic [AW-1:0]         wr_addr_q, wr_addr_d;
  logic [AW-1:0]         rd_addr_q, rd_addr_d;

  logic wr_fire, wr_close, rd_valid, rd_last, rd_fire;

  assign wr_fire  = bus.valid && !full_q[wr_sel_q];
  assign wr_close = wr_fire && ((wr_addr_q == AW'(BANK_DEPTH - 1)) || bus.last_input);
  assign rd_valid = full_q[rd_sel_q];
  assign rd_last  = rd_valid && ((LW'(rd_addr_q) + LW'(1)) == len_q[rd_sel_q]);
  assign rd_fire  = rd_valid && bus.data_out_ready;

  // A write needs !full and a read needs full, so both never target one bank.
  always_comb begin
    full_d    = full_q;
    len_d     = len_q;
    wr_sel_d  = wr_sel_q;
    wr_addr_d = wr_addr_q;
    rd_sel_d  = rd_sel_q;
    rd_addr_d = rd_addr_q;
    if (wr_fire) begin
      if (wr_close) begin
        full_d[wr_sel_q] = 1'b1;
        len_d[wr_sel_q]  = LW'(wr_addr_q) + LW'(1);
        wr_sel_d         = !wr_sel_q;
        wr_addr_d        = '0;
      end else begin
        wr_addr_d = wr_addr_q + AW'(1);
      end
    end
    if (rd_fire) begin
      if (rd_last) begin
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = !rd_sel_q;
        rd_addr_d        = '0;
      end else begin
        rd_addr_d = rd_addr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      full_q    <= '0;
      len_q[0]  <= '0;
      len_q[1]  <= '0;
      wr_sel_q  <= 1'b0;
      wr_addr_q <= '0;
      rd_sel_q  <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      full_q    <= full_d;
      len_q     <= len_d;
      wr_sel_q  <= wr_sel_d;
      wr_addr_q <= wr_addr_d;
      rd_sel_q  <= rd_sel_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_fire) begin
      mem_q[wr_sel_q][wr_addr_q] <= bus.data_input;
    end
  end

  // Every output is register-derived; ready_input has no path from data_out_ready.
  assign bus.ready_input    = !full_q[wr_sel_q];
  assign bus.data_out_valid = rd_valid;
  assign bus.data_out_last  = rd_last;
  assign bus.data_output    = rd_valid ? mem_q[rd_sel_q][rd_addr_q] : '0;
  assign bus.bank_full      = full_q;
endmodule
